// File: rtl/output_port.sv
// rtl/output_port.sv - buffered character output port with printer handshake FSM
module output_port #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       load_in,
    input  logic       ien_in,
    output logic       fgo_out,
    output logic       int_out,
    output logic       overflow_out,
    output logic [7:0] printer_data_out,
    output logic       printer_fgo_out,
    input  logic       printer_clear_in
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          push;
    logic          pop;
    logic          present_start;

    // A load is accepted only when the buffer had room before this edge;
    // a same-edge pop does not make room for it.
    assign full    = (count == FULL);
    assign push    = load_in && !full;
    assign fgo_out = !full;
    assign int_out = ien_in && fgo_out;

    // Printer handshake state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Printer handshake next state, pop request and printer flag
    always_comb begin
        state_next      = state;
        printer_fgo_out = 1'b1;
        present_start   = 1'b0;
        pop             = 1'b0;
        case (state)
            IDLE: begin
                // A clear still held high (e.g. across reset) blocks presentation
                if (count != '0 && !printer_clear_in) begin
                    state_next    = PRESENT;
                    present_start = 1'b1;
                end
            end
            PRESENT: begin
                printer_fgo_out = 1'b0;
                if (printer_clear_in) begin
                    state_next = RELEASE;
                    pop        = 1'b1;
                end
            end
            RELEASE: begin
                if (!printer_clear_in) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Character storage; contents need no reset since count gates every read
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy count; push and pop together leave it unchanged
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: a load arriving while full is dropped and flagged
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_out <= 1'b0;
        end else if (load_in && full) begin
            overflow_out <= 1'b1;
        end
    end

    // Capture the head character as the printer is offered it, then hold it
    always_ff @(posedge clock) begin
        if (reset) begin
            printer_data_out <= 8'h00;
        end else if (present_start) begin
            printer_data_out <= mem[rd_ptr];
        end
    end

endmodule
